// File: rtl/data_sync_launch.sv
// Source-domain launcher for a multi-cycle-path bus synchronizer: captures a word,
// holds it on unsync_bus and runs a 4-phase request/ack handshake with the destination.
module data_sync_launch #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int TIMEOUT    = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic                 ack_async,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 done_pulse,
  output logic                 timeout_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] REQ     = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]            state;
  logic [NUM_STAGES-1:0] ack_p0;
  logic                  ack_sync;
  logic [CNT_W-1:0]      req_cnt;
  logic                  accept;

  // Last REQ cycle before the word is abandoned; never true when TIMEOUT is 0.
  function automatic logic at_limit(input logic [CNT_W-1:0] cnt);
    return (TIMEOUT != 0) && (cnt == CNT_LAST);
  endfunction

  // ack_async synchronizer chain
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ack_p0 <= '0;
    else      ack_p0 <= {ack_p0[NUM_STAGES-2:0], ack_async};
  end

  assign ack_sync  = ack_p0[NUM_STAGES-1];
  // A stale ack still high from the last word must drain before a new accept.
  assign src_ready = (state == IDLE) && !ack_sync;
  assign accept    = src_valid && src_ready;

  // Handshake FSM
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      unsync_bus  <= '0;
      bus_enable  <= 1'b0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      req_cnt     <= '0;
    end else begin
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            unsync_bus <= src_data;
            state      <= LOAD;
          end
        end
        LOAD: begin
          bus_enable <= 1'b1;
          req_cnt    <= '0;
          state      <= REQ;
        end
        REQ: begin
          if (TIMEOUT != 0) req_cnt <= req_cnt + CNT_W'(1);
          if (ack_sync) begin
            bus_enable <= 1'b0;
            done_pulse <= 1'b1;
            state      <= RELEASE;
          end else if (at_limit(req_cnt)) begin
            bus_enable  <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          bus_enable <= 1'b0;
          if (!ack_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
